// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer: the entry record and a
// byte-lane merge used when a store coalesces into a buffered entry.
package sb_pkg;

    localparam int SB_LANES         = 4;
    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_AW            = 32;

    typedef struct packed {
        logic                valid;
        logic [SB_AW-3:0]    waddr;
        logic [31:0]         data;
        logic [SB_LANES-1:0] bmask;
    } sb_entry_t;

    // Lanes enabled in mask take the new byte; all others keep the old one.
    function automatic logic [31:0] sb_merge(input logic [31:0]         old_data,
                                             input logic [31:0]         new_data,
                                             input logic [SB_LANES-1:0] mask);
        logic [31:0] r;
        r = old_data;
        for (int b = 0; b < SB_LANES; b++) begin
            if (mask[b]) begin
                r[8*b +: 8] = new_data[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/store_buffer_fwd.sv
// Store-to-load forwarding: per byte lane, the youngest valid entry whose word
// address matches the load and whose mask covers that lane supplies the byte.
module store_buffer_fwd
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    localparam int PW   = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [PW-1:0]         head,
    input  logic [SB_AW-3:0]      ld_waddr,
    input  logic [SB_LANES-1:0]   ld_bmask,
    output logic [31:0]           fwd_data,
    output logic [SB_LANES-1:0]   fwd_mask,
    output logic                  full_hit
);

    logic [SB_LANES-1:0] supplied;

    // Walk oldest to youngest from the head so later matches override earlier ones.
    always_comb begin
        fwd_data = '0;
        supplied = '0;
        fwd_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            for (int b = 0; b < SB_LANES; b++) begin
                if (entries[PW'(head + PW'(k))].valid &&
                    entries[PW'(head + PW'(k))].waddr == ld_waddr &&
                    entries[PW'(head + PW'(k))].bmask[b]) begin
                    supplied[b]        = 1'b1;
                    fwd_data[8*b +: 8] = entries[PW'(head + PW'(k))].data[8*b +: 8];
                end
            end
        end
        fwd_mask = supplied & ld_bmask;
        for (int b = 0; b < SB_LANES; b++) begin
            if (!fwd_mask[b]) begin
                fwd_data[8*b +: 8] = 8'h00;
            end
        end
    end

    assign full_hit = (ld_bmask != '0) && (fwd_mask == ld_bmask);

endmodule

// File: rtl/store_buffer.sv
// In-order store write buffer with same-word coalescing into the youngest
// non-head entry, a valid/ready drain port to memory and byte-level forwarding.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_st_valid,
    input  logic [AW-1:0]          i_st_addr,
    input  logic [31:0]            i_st_data,
    input  logic [3:0]             i_st_bmask,
    output logic                   o_st_ready,
    output logic                   o_mem_wr_valid,
    output logic [AW-1:0]          o_mem_addr,
    output logic [31:0]            o_mem_wdata,
    output logic [3:0]             o_mem_bmask,
    input  logic                   i_mem_wr_ready,
    input  logic [AW-1:0]          i_ld_addr,
    input  logic [3:0]             i_ld_bmask,
    output logic [31:0]            o_ld_fwd_data,
    output logic [3:0]             o_ld_fwd_mask,
    output logic                   o_ld_full_hit,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshakes: a store moves when i_st_valid && o_st_ready; the head entry
    // moves when o_mem_wr_valid && i_mem_wr_ready. Ready/valid never look at
    // the partner's signal in the same cycle.
    sb_entry_t [DEPTH-1:0] entries;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW-1:0]         youngest;
    logic [CW-1:0]         count;
    logic [AW-3:0]         st_waddr;
    logic                  take;
    logic                  coalesce;
    logic                  enq;
    logic                  deq;
    sb_entry_t             new_entry;

    assign st_waddr = i_st_addr[AW-1:2];
    assign youngest = tail - PW'(1);

    assign o_st_ready     = (count != CW'(DEPTH));
    assign o_mem_wr_valid = (count != '0);
    assign o_mem_addr     = {entries[head].waddr, 2'b00};
    assign o_mem_wdata    = entries[head].data;
    assign o_mem_bmask    = entries[head].bmask;
    assign o_count        = count;
    assign o_empty        = (count == '0);

    // Zero-mask stores complete the handshake but leave no trace.
    assign take     = i_st_valid && o_st_ready && (i_st_bmask != 4'b0000);
    // count >= 2 keeps the youngest entry distinct from the head being presented.
    assign coalesce = take && (count >= CW'(2)) && (entries[youngest].waddr == st_waddr);
    assign enq      = take && !coalesce;
    assign deq      = o_mem_wr_valid && i_mem_wr_ready;

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.waddr = st_waddr;
        new_entry.data  = i_st_data;
        new_entry.bmask = i_st_bmask;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            entries <= '0;
        end else begin
            if (deq) begin
                entries[head].valid <= 1'b0;
                entries[head].bmask <= '0;
                head                <= head + PW'(1);
            end
            if (enq) begin
                entries[tail] <= new_entry;
                tail          <= tail + PW'(1);
            end
            if (coalesce) begin
                entries[youngest].data  <= sb_merge(entries[youngest].data, i_st_data, i_st_bmask);
                entries[youngest].bmask <= entries[youngest].bmask | i_st_bmask;
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    store_buffer_fwd #(.DEPTH(DEPTH)) u_fwd (
        .entries  (entries),
        .head     (head),
        .ld_waddr (i_ld_addr[AW-1:2]),
        .ld_bmask (i_ld_bmask),
        .fwd_data (o_ld_fwd_data),
        .fwd_mask (o_ld_fwd_mask),
        .full_hit (o_ld_full_hit)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed cases with literal expectations, then random
// traffic compared every cycle against a queue-based model of the buffer.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int W     = 66;  // {waddr[29:0], data[31:0], bmask[3:0]}

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_bmask;
    logic        st_ready;
    logic        mem_wr_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_ready;
    logic [31:0] ld_addr;
    logic [3:0]  ld_bmask;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_mask;
    logic        full_hit;
    logic [2:0]  count;
    logic        empty;

    logic [W-1:0] exp_q[$];
    int           n_total;
    int           n_pass;
    bit           chk_en;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_st_valid     (st_valid),
        .i_st_addr      (st_addr),
        .i_st_data      (st_data),
        .i_st_bmask     (st_bmask),
        .o_st_ready     (st_ready),
        .o_mem_wr_valid (mem_wr_valid),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_bmask    (mem_bmask),
        .i_mem_wr_ready (mem_ready),
        .i_ld_addr      (ld_addr),
        .i_ld_bmask     (ld_bmask),
        .o_ld_fwd_data  (fwd_data),
        .o_ld_fwd_mask  (fwd_mask),
        .o_ld_full_hit  (full_hit),
        .o_count        (count),
        .o_empty        (empty)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] merge_bytes(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Reference model: the buffer is an ordered list of pending word writes.
    always @(posedge clk) begin : model
        int           sz;
        bit           take;
        bit           drain;
        bit           merge;
        logic [W-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            sz    = exp_q.size();
            take  = st_valid && (sz != DEPTH) && (st_bmask != 4'b0);
            drain = (sz != 0) && mem_ready;
            merge = take && (sz >= 2) && (exp_q[sz-1][65:36] == st_addr[31:2]);
            if (merge) begin
                e         = exp_q[sz-1];
                e[35:4]   = merge_bytes(e[35:4], st_data, st_bmask);
                e[3:0]    = e[3:0] | st_bmask;
                exp_q[sz-1] = e;
            end
            if (drain) void'(exp_q.pop_front());
            if (take && !merge) exp_q.push_back({st_addr[31:2], st_data, st_bmask});
        end
    end

    // Scoreboard compare, every cycle once reset has been applied.
    always @(negedge clk) begin : compare
        int           sz;
        logic [W-1:0] e;
        logic [31:0]  fd;
        logic [3:0]   fm;
        if (chk_en) begin
            sz = exp_q.size();
            check("count", count, sz);
            check("empty", empty, sz == 0);
            check("st_ready", st_ready, sz != DEPTH);
            check("mem_valid", mem_wr_valid, sz != 0);
            if (sz != 0) begin
                e = exp_q[0];
                check("mem_addr", mem_addr, {e[65:36], 2'b00});
                check("mem_wdata", mem_wdata, e[35:4]);
                check("mem_bmask", mem_bmask, e[3:0]);
            end
            fd = '0;
            fm = '0;
            for (int b = 0; b < 4; b++) begin
                for (int i = sz - 1; i >= 0; i--) begin
                    e = exp_q[i];
                    if (e[65:36] == ld_addr[31:2] && e[b]) begin
                        fm[b] = 1'b1;
                        fd[8*b +: 8] = e[4 + 8*b +: 8];
                        break;
                    end
                end
            end
            fm = fm & ld_bmask;
            for (int b = 0; b < 4; b++) if (!fm[b]) fd[8*b +: 8] = 8'h00;
            check("fwd_data", fwd_data, fd);
            check("fwd_mask", fwd_mask, fm);
            check("full_hit", full_hit, (ld_bmask != 4'b0) && (fm == ld_bmask));
        end
    end

    // Driver tasks: step ends just after a rising edge, settle just after a falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_bmask = m;
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        chk_en    = 1'b0;
        rst_n     = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_bmask  = '0;
        mem_ready = 1'b0;
        ld_addr   = '0;
        ld_bmask  = '0;
        step();
        chk_en = 1'b1;
        repeat (2) step();
        settle();
        check("rst_mem_valid", mem_wr_valid, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_bmask", mem_bmask, 4'h0);
        check("rst_st_ready", st_ready, 1'b1);
        check("rst_empty", empty, 1'b1);
        check("rst_count", count, 3'd0);
        step();
        rst_n = 1'b1;

        // Single store latency
        mem_ready = 1'b1;
        store(32'h100, 32'h0000_00AB, 4'b0001);
        settle();
        check("t1_valid", mem_wr_valid, 1'b1);
        check("t1_addr", mem_addr, 32'h100);
        check("t1_wdata", mem_wdata, 32'h0000_00AB);
        check("t1_bmask", mem_bmask, 4'b0001);
        step();
        settle();
        check("t1_empty_after", empty, 1'b1);
        step();

        // Backpressure, full, drain while full
        mem_ready = 1'b0;
        store(32'h0, 32'h0000_0001, 4'hF);
        store(32'h4, 32'h0000_0002, 4'hF);
        store(32'h8, 32'h0000_0003, 4'hF);
        store(32'hC, 32'h0000_0004, 4'hF);
        settle();
        check("t2_count_full", count, 3'd4);
        check("t2_ready_full", st_ready, 1'b0);
        check("t2_head_addr", mem_addr, 32'h0);
        step();
        mem_ready = 1'b1;
        st_valid  = 1'b1;
        st_addr   = 32'h50;
        st_data   = 32'hFFFF_FFFF;
        st_bmask  = 4'hF;
        settle();
        check("t2_ready_during_drain", st_ready, 1'b0);
        step();
        st_valid  = 1'b0;
        mem_ready = 1'b0;
        settle();
        check("t2_count_after", count, 3'd3);
        check("t2_ready_after", st_ready, 1'b1);
        check("t2_next_head", mem_addr, 32'h4);
        step();
        mem_ready = 1'b1;
        repeat (4) step();
        mem_ready = 1'b0;

        // Coalesce with count >= 2
        store(32'h10, 32'h1111_1111, 4'b1111);
        store(32'h20, 32'h0000_BBBB, 4'b0011);
        store(32'h20, 32'hCCCC_0000, 4'b1100);
        settle();
        check("t3_count", count, 3'd2);
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        settle();
        check("t3_addr", mem_addr, 32'h20);
        check("t3_wdata", mem_wdata, 32'hCCCC_BBBB);
        check("t3_bmask", mem_bmask, 4'b1111);
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;

        // No coalesce into the head (count 1)
        store(32'h30, 32'h0000_BBBB, 4'b0011);
        store(32'h30, 32'hCCCC_0000, 4'b1100);
        settle();
        check("t3b_count", count, 3'd2);
        check("t3b_wdata", mem_wdata, 32'h0000_BBBB);
        check("t3b_bmask", mem_bmask, 4'b0011);
        step();
        mem_ready = 1'b1;
        repeat (2) step();
        mem_ready = 1'b0;

        // Forwarding priority
        store(32'h40, 32'h1122_3344, 4'b1111);
        store(32'h40, 32'h0000_00AA, 4'b0001);
        ld_addr  = 32'h40;
        ld_bmask = 4'hF;
        settle();
        check("t4_fwd_data", fwd_data, 32'h1122_33AA);
        check("t4_fwd_mask", fwd_mask, 4'b1111);
        check("t4_full_hit", full_hit, 1'b1);
        step();
        ld_addr = 32'h44;
        settle();
        check("t4_miss_mask", fwd_mask, 4'b0000);
        check("t4_miss_hit", full_hit, 1'b0);
        step();
        mem_ready = 1'b1;
        repeat (2) step();
        mem_ready = 1'b0;

        // Partial hit and zero-mask store
        store(32'h80, 32'h0000_5566, 4'b0011);
        ld_addr  = 32'h80;
        ld_bmask = 4'hF;
        settle();
        check("t5_mask", fwd_mask, 4'b0011);
        check("t5_hit", full_hit, 1'b0);
        check("t5_data", fwd_data, 32'h0000_5566);
        step();
        store(32'h80, 32'hDEAD_BEEF, 4'b0000);
        settle();
        check("t5_zero_mask_count", count, 3'd1);
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;

        // Reset mid-operation
        store(32'h200, 32'hA, 4'hF);
        store(32'h204, 32'hB, 4'hF);
        store(32'h208, 32'hC, 4'hF);
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        settle();
        check("t6_valid", mem_wr_valid, 1'b0);
        check("t6_count", count, 3'd0);
        check("t6_empty", empty, 1'b1);
        step();
        settle();
        check("t6_valid_later", mem_wr_valid, 1'b0);
        step();

        // Random traffic on a small address window
        for (int c = 0; c < 800; c++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            st_valid  = ($urandom_range(0, 9) < 7);
            st_addr   = 32'h300 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
            st_data   = $urandom;
            st_bmask  = 4'($urandom_range(0, 15));
            mem_ready = ($urandom_range(0, 1) == 1);
            ld_addr   = 32'h300 + 32'($urandom_range(0, 4)) * 4;
            ld_bmask  = 4'($urandom_range(0, 15));
            step();
        end
        rst_n    = 1'b1;
        st_valid = 1'b0;
        settle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order write buffer directly downstream of the store data/byte-mask formatting stage.
- Accepts lane-aligned store data and a byte-enable mask, queues them, and drains them to the data-memory write port with a valid/ready handshake.
- Provides byte-granular store-to-load forwarding so younger loads observe buffered stores.
- Merges consecutive stores to the same word into the youngest non-draining entry.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- AW, 32, byte-address width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_st_valid  in  1  store request from the store formatting stage
- i_st_addr  in  AW  store byte address; only [AW-1:2] is used
- i_st_data  in  32  lane-aligned store data
- i_st_bmask  in  4  byte enables
- o_st_ready  out  1  buffer can accept a store
- o_mem_wr_valid  out  1  head entry presented to memory
- o_mem_addr  out  AW  word-aligned address; [1:0] is always 0
- o_mem_wdata  out  32  head entry data
- o_mem_bmask  out  4  head entry byte enables
- i_mem_wr_ready  in  1  memory accepts the head entry
- i_ld_addr  in  AW  load address for the forwarding lookup
- i_ld_bmask  in  4  bytes the load needs
- o_ld_fwd_data  out  32  forwarded bytes; lanes not forwarded read as 0
- o_ld_fwd_mask  out  4  lanes supplied by the buffer
- o_ld_full_hit  out  1  every requested lane is forwarded
- o_count  out  $clog2(DEPTH)+1  occupied entries
- o_empty  out  1  count == 0

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - Pointers, count and all entry valid/bmask bits clear.
  - o_mem_wr_valid=0, o_mem_addr=0, o_mem_wdata=0, o_mem_bmask=0, o_st_ready=1, o_empty=1, o_count=0.
  - Reset mid-drain discards all entries, with no further memory writes.
- Accept:
  - o_st_ready = (count != DEPTH). It has no combinational dependency on i_st_valid, i_st_addr or i_mem_wr_ready.
  - A store is taken when i_st_valid && o_st_ready.
  - A store with i_st_bmask == 0 is accepted and dropped; no state changes.
- Coalesce:
  - Condition: the store is taken, count >= 2, and the youngest entry's word address equals i_st_addr[AW-1:2].
  - Each lane with bmask[b]=1 overwrites that byte of the youngest entry; the entry mask becomes old | new.
  - Count is unchanged.
  - Coalescing is never done into the head entry, so the memory-port data stays stable.
- Enqueue: a taken store that does not coalesce is written at the tail; tail+1 and count+1.
- Drain:
  - o_mem_* are driven straight from the head entry registers.
  - o_mem_wr_valid = !empty.
  - On o_mem_wr_valid && i_mem_wr_ready: head+1 and count-1.
  - Valid, address, data and mask stay stable until the handshake completes.
- Latency: a store taken into an empty buffer appears on o_mem_* in the next cycle.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance. This is legal whenever ready=1.
- Full buffer:
  - o_st_ready=0 even if a drain occurs in the same cycle.
  - Ready returns in the cycle after the drain.
- Pointer wrap: pointers wrap modulo DEPTH. Full/empty is decided from count, not from pointer equality.
- Forwarding (combinational):
  - For each lane b, take the youngest valid entry whose word address matches i_ld_addr[AW-1:2] and whose bmask[b]=1. That entry supplies byte b.
  - o_ld_fwd_mask = supplied lanes & i_ld_bmask.
  - o_ld_full_hit = (i_ld_bmask != 0) && (o_ld_fwd_mask == i_ld_bmask).
  - The head entry draining in the current cycle still forwards in that cycle.
  - A store taken in the current cycle forwards from the next cycle onward.

Decomposition:
- Package sb_pkg:
  - sb_entry_t struct: valid, waddr[AW-3:0], data[31:0], bmask[3:0].
  - Constants SB_LANES=4 and SB_DEPTH_DEFAULT=4.
  - Helper function for byte-lane merge.
- Sub-module store_buffer_fwd: purely combinational per-lane youngest-match priority select over the entry array, indexed relative to the head pointer.
- The top level holds the pointers, count, coalesce logic and handshake.

Test Plan:
- Reset then a single store: addr 0x100, data 0x0000_00AB, bmask 0001, mem ready=1 -> next cycle o_mem_wr_valid=1, addr 0x100, wdata 0x0000_00AB, bmask 0001; buffer empty the cycle after.
- Backpressure and full: ready=0, four stores to 0x0, 0x4, 0x8, 0xC -> o_count=4, o_st_ready=0. Raise ready for one cycle -> one drain of 0x0; o_st_ready=1 on the following cycle. Memory outputs stay stable throughout the stall.
- Coalesce: ready=0, stores 0x10/bmask 1111/0x11111111, then 0x20/bmask 0011/0x0000BBBB, then 0x20/bmask 1100/0xCCCC0000 -> count=2; second entry drains as 0xCCCCBBBB with bmask 1111. Same case with count=1 -> no merge, count=2.
- Forwarding priority: buffered 0x40/bmask 1111/0x11223344, then 0x40/bmask 0001/0x000000AA (count 1 at the second store, so no merge). Load 0x40 with bmask 1111 -> fwd_data 0x112233AA, fwd_mask 1111, full_hit=1. Load 0x44 -> fwd_mask 0000, full_hit=0.
- Partial hit and zero mask: buffered 0x80/bmask 0011; load with bmask 1111 -> fwd_mask 0011, full_hit=0. A store with bmask 0000 leaves count unchanged.
- Reset mid-operation: three entries queued with ready=0, assert i_rst_n=0 for one cycle, then ready=1 -> no o_mem_wr_valid, o_count=0, o_empty=1.
